// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_pkg
//  Description : Shared float32 field widths, constants, FSM state encoding
//                and operand classification used by the fp32 datapath blocks
//                (multiplier, reciprocal, adder, divider).
//  Revision    : 1.0 - initial release
// ============================================================================
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Zero and subnormal share a class: subnormal inputs are treated as zero.
    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fclass_e;

    function automatic fclass_e fp32_classify(input logic [31:0] x);
        fclass_e c;
        if (x[30:23] == '0)
            c = CLS_ZERO;
        else if (x[30:23] == '1)
            c = (x[22:0] != '0) ? CLS_NAN : CLS_INF;
        else
            c = CLS_NORMAL;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_pack.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_pack
//  Description : Combinational normalise / round / pack of a 48-bit mantissa
//                product into float32, with special-operand resolution,
//                overflow to infinity and flush-to-zero underflow.
//                FMUL_F32_ROUND_EN defined -> round-to-nearest-even,
//                otherwise truncate.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp32_pack
    import fp32_pkg::*;
(
    input  logic              sign_i,
    input  logic signed [9:0] exp_i,
    input  logic [47:0]       prod_i,
    input  fclass_e           cls_a_i,
    input  fclass_e           cls_b_i,
    output logic [31:0]       res_o
);

`ifdef FMUL_F32_ROUND_EN
    localparam logic c_RNE = 1'b1;
`else
    localparam logic c_RNE = 1'b0;
`endif

    logic [FRAC_W-1:0] frac;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [FRAC_W:0]   mant_rnd;
    logic signed [9:0] exp_norm;
    logic signed [9:0] exp_fin;
    logic              any_nan;
    logic              any_inf;
    logic              any_zero;

    // Normalise on bit 47, round, then resolve specials and range limits.
    always_comb begin
        if (prod_i[47]) begin
            frac     = prod_i[46:24];
            guard    = prod_i[23];
            sticky   = |prod_i[22:0];
            exp_norm = exp_i + 10'sd1;
        end else begin
            frac     = prod_i[45:23];
            guard    = prod_i[22];
            sticky   = |prod_i[21:0];
            exp_norm = exp_i;
        end

        // Truncating build leaves c_RNE low so the increment folds away.
        inc      = c_RNE & guard & (sticky | frac[0]);
        mant_rnd = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};
        // A carry out leaves the fraction all-zero: just bump the exponent.
        exp_fin  = exp_norm + {9'd0, mant_rnd[FRAC_W]};

        any_nan  = (cls_a_i == CLS_NAN) || (cls_b_i == CLS_NAN) ||
                   ((cls_a_i == CLS_INF) && (cls_b_i == CLS_ZERO)) ||
                   ((cls_a_i == CLS_ZERO) && (cls_b_i == CLS_INF));
        any_inf  = (cls_a_i == CLS_INF) || (cls_b_i == CLS_INF);
        any_zero = (cls_a_i == CLS_ZERO) || (cls_b_i == CLS_ZERO);

        if (any_nan)
            res_o = QNAN;
        else if (any_inf)
            res_o = {sign_i, POS_INF[30:0]};
        else if (any_zero)
            res_o = {sign_i, 31'h0};
        else if (exp_fin >= 10'sd255)
            res_o = {sign_i, POS_INF[30:0]};
        else if (exp_fin <= 10'sd0)
            res_o = {sign_i, 31'h0};
        else
            res_o = {sign_i, exp_fin[EXP_W-1:0], mant_rnd[FRAC_W-1:0]};
    end

endmodule
`default_nettype wire

// File: rtl/fmul_f32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fmul_f32_seq
//  Description : Sequential float32 multiplier, start/rdy handshake,
//                24-step shift-add mantissa multiply then one normalise/pack
//                cycle (25 cycles from accept to rdy).
//                FMUL_F32_ROUND_EN defined -> round-to-nearest-even,
//                otherwise truncate.
//  Revision    : 1.0 - initial release
// ============================================================================
module fmul_f32_seq
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        rdy,
    output logic [31:0] m
);

    state_e            state_q;
    logic [4:0]        cnt_q;
    logic [47:0]       acc_q;
    logic [47:0]       acc_d;
    logic              sign_q;
    logic [EXP_W-1:0]  ea_q;
    logic [EXP_W-1:0]  eb_q;
    logic [23:0]       ma_q;
    logic [23:0]       mb_q;
    fclass_e           cls_a_q;
    fclass_e           cls_b_q;
    logic              rdy_q;
    logic [31:0]       m_q;
    logic signed [9:0] exp_sum;
    logic [31:0]       pack_res;

    // Next accumulator value for the current shift-add step, and the biased
    // exponent sum consumed by the pack stage.
    always_comb begin
        acc_d   = mb_q[cnt_q] ? (acc_q + ({24'd0, ma_q} << cnt_q)) : acc_q;
        exp_sum = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
    end

    fp32_pack u_pack (
        .sign_i  (sign_q),
        .exp_i   (exp_sum),
        .prod_i  (acc_q),
        .cls_a_i (cls_a_q),
        .cls_b_i (cls_b_q),
        .res_o   (pack_res)
    );

    // Control FSM with datapath registers; operands latched only on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sign_q  <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            cls_a_q <= CLS_ZERO;
            cls_b_q <= CLS_ZERO;
            rdy_q   <= 1'b0;
            m_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sign_q  <= a[31] ^ b[31];
                        ea_q    <= a[30:23];
                        eb_q    <= b[30:23];
                        ma_q    <= {(a[30:23] != '0), a[22:0]};
                        mb_q    <= {(b[30:23] != '0), b[22:0]};
                        cls_a_q <= fp32_classify(a);
                        cls_b_q <= fp32_classify(b);
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        rdy_q   <= 1'b0;
                        state_q <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc_q <= acc_d;
                    if (cnt_q == 5'd23) begin
                        cnt_q   <= '0;
                        state_q <= ST_NORM;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_NORM: begin
                    m_q     <= pack_res;
                    rdy_q   <= 1'b1;
                    state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rdy = rdy_q;
    assign m   = m_q;

endmodule
`default_nettype wire

// File: tb/tb_fmul_f32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fmul_f32_seq
//  Description : Self-checking bench for fmul_f32_seq. Expected products come
//                from directed constants and an independent reference model
//                and are queued at issue time, then popped when rdy rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fmul_f32_seq;

`ifdef FMUL_F32_ROUND_EN
    localparam bit          c_ROUND_EN = 1'b1;
    localparam logic [31:0] c_RND_EXP  = 32'h3FC0_0003;
`else
    localparam bit          c_ROUND_EN = 1'b0;
    localparam logic [31:0] c_RND_EXP  = 32'h3FC0_0002;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        rdy;
    logic [31:0] m;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    fmul_f32_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (op_a),
        .b     (op_b),
        .rdy   (rdy),
        .m     (m)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (n_checks=%0d)", n_checks);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp_v);
        end
    endtask

    // Independent float32 product model (direct 24x24 multiply).
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        logic [47:0] p;
        logic [22:0] f;
        logic        g;
        logic        st;
        logic [23:0] r;
        int          e;
        bit          xn, yn, xi, yi, xz, yz;
        s  = x[31] ^ y[31];
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        xz = (x[30:23] == 8'h00);
        yz = (y[30:23] == 8'h00);
        if (xn || yn || (xi && yz) || (yi && xz)) return 32'h7FC0_0000;
        if (xi || yi) return {s, 8'hFF, 23'h0};
        if (xz || yz) return {s, 31'h0};
        p = {24'h0, 1'b1, x[22:0]} * {24'h0, 1'b1, y[22:0]};
        e = int'(x[30:23]) + int'(y[30:23]) - 127;
        if (p[47]) begin
            f = p[46:24]; g = p[23]; st = |p[22:0]; e = e + 1;
        end else begin
            f = p[45:23]; g = p[22]; st = |p[21:0];
        end
        if (c_ROUND_EN && g && (st || f[0])) begin
            r = {1'b0, f} + 24'd1;
            if (r[23]) e = e + 1;
            f = r[22:0];
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], f};
    endfunction

    // Present operands with start for one accepted edge; queue the expectation.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp_v);
        @(negedge clk);
        op_a  = x;
        op_b  = y;
        start = 1'b1;
        exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = ~x;
        op_b  = ~y;
        check_eq("rdy clears on accept", {31'd0, rdy}, 32'd0);
    endtask

    // Wait (bounded) for rdy, check latency and the popped expectation.
    task automatic wait_result(input string tag);
        int          k;
        logic [31:0] exp_v;
        k = 0;
        while (k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (rdy) break;
        end
        if (!rdy) k = 99;
        check_eq({tag, " latency"}, k, 32'd25);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check_eq(tag, m, exp_v);
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_v, input string tag);
        issue(x, y, exp_v);
        wait_result(tag);
        @(posedge clk);
        #1;
        check_eq({tag, " hold"}, {rdy, m[30:0]}, {1'b1, exp_v[30:0]});
    endtask

    initial begin
        bit          seen;
        logic [31:0] x;
        logic [31:0] y;

        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset rdy", {31'd0, rdy}, 32'd0);
        check_eq("reset m", m, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, "2x3");
        run_op(32'h3FC0_0000, 32'hBF00_0000, 32'hBF40_0000, "1.5x-0.5");

        // Abort an operation with reset partway through MUL.
        @(negedge clk);
        op_a  = 32'h4000_0000;
        op_b  = 32'h4040_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort rdy", {31'd0, rdy}, 32'd0);
        check_eq("abort m", m, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (rdy) seen = 1'b1;
        end
        check_eq("no rdy after abort", {31'd0, seen}, 32'd0);

        run_op(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, "overflow");
        run_op(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, "subnormal flush");
        run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, "inf x 0");
        run_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, "-inf x 2");
        run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, "nan x 1");
        run_op(32'h0000_0000, 32'hC040_0000, 32'h8000_0000, "0 x -3");
        run_op(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, "underflow");
        run_op(32'h3FC0_0001, 32'h3F80_0001, c_RND_EXP, "rounding");

        // Back-to-back: start held high throughout, operands swapped mid-MUL.
        @(negedge clk);
        op_a  = 32'h4010_0000;
        op_b  = 32'hC020_0000;
        start = 1'b1;
        exp_q.push_back(32'hC0B4_0000);
        @(posedge clk);
        #1;
        op_a = 32'h4040_0000;
        op_b = 32'h4080_0000;
        wait_result("b2b first");
        exp_q.push_back(32'h4140_0000);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("b2b relaunch rdy", {31'd0, rdy}, 32'd0);
        op_a = 32'h0;
        op_b = 32'h0;
        wait_result("b2b second");

        // Randomised operands against the reference model.
        for (int i = 0; i < 24; i++) begin
            if (i[0]) begin
                x = $urandom;
                y = $urandom;
            end else begin
                x = {1'($urandom), 8'(100 + $urandom_range(0, 54)), 23'($urandom)};
                y = {1'($urandom), 8'(100 + $urandom_range(0, 54)), 23'($urandom)};
            end
            run_op(x, y, ref_mul(x, y), $sformatf("rand%0d %08h*%08h", i, x, y));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
